pixel_write_controller: RTL and testbench
=========================================

Name: pixel_write_controller

Overview:
- Sits directly downstream of the MCU message broker. It consumes the broker's 12-bit assembled pixel and its pixel strobe, which live in the MCU bus clock domain.
- Synchronises the strobe into the system clock domain and buffers pixels in a small FIFO.
- Drains the FIFO to the framebuffer memory through a request/acknowledge write port, generating sequential raster addresses that wrap at end of frame.
- Frame restart, driven by the command path, re-homes the write address to pixel 0.

Parameters:
FRAME_WIDTH, 320, pixels per line
FRAME_HEIGHT, 240, lines per frame
ADDR_WIDTH, 17, framebuffer address width; must satisfy 2^ADDR_WIDTH >= FRAME_WIDTH*FRAME_HEIGHT
FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 2

Ports:
system_clock  in  1  single clock for the whole block
reset_n  in  1  asynchronous, active-low reset
pixel_clock  in  1  pixel strobe from broker, asynchronous to system_clock; rising edge means new pixel
pixel_data  in  12  pixel value, stable from pixel_clock rise until the broker's next data-clock edge
frame_restart  in  1  system_clock-domain single-cycle pulse; restart raster at address 0
mem_address  out  ADDR_WIDTH  framebuffer write address
mem_data  out  12  framebuffer write data
mem_write_request  out  1  write request, held until acknowledged
mem_write_ack  in  1  memory accepts current write on a cycle it is high while request is high
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
fifo_overflow  out  1  sticky; a pixel was dropped because the FIFO was full
busy  out  1  high when FIFO not empty or a write is outstanding

Behaviour:
- Reset (async assert, sync-safe release): mem_address=0, mem_data=0, mem_write_request=0, fifo_level=0, fifo_overflow=0, busy=0, FSM=IDLE.
- Reset, synchroniser and edge flops: all synchroniser and edge-detect flops reset to 1. A pixel_clock already high at release therefore produces no spurious push.
- Strobe sync: 2-flop synchroniser plus 1 edge flop. A rising edge is detected when sync=1 and edge=0.
- Push: the push cycle is exactly 3 system_clock cycles after pixel_clock is sampled high by the first flop. pixel_data is registered into the FIFO on the push cycle.
- Environment requirement: consecutive pixel_clock rises must be >= 4 system_clock periods apart, and pixel_data must stay stable >= 4 periods after the rise.
- Full FIFO: a push when fifo_level==FIFO_DEPTH (pre-cycle value) drops the pixel and sets fifo_overflow. This applies even if a pop occurs in the same cycle.
- fifo_overflow clears only on reset.
- Simultaneous push and pop when not full: level unchanged, both take effect.
- FSM state IDLE: if FIFO not empty, next cycle load mem_data with FIFO head and mem_address with the current raster address, assert mem_write_request, and go to REQUEST.
- FSM state REQUEST: mem_address, mem_data and request are held stable until mem_write_ack=1.
- FSM on ack cycle: pop the FIFO and advance the raster address. The address becomes 0 if it was FRAME_WIDTH*FRAME_HEIGHT-1, otherwise +1. Request drops next cycle; return to IDLE.
- Throughput: at most one write per 2 cycles.
- mem_write_ack while request is low is ignored.
- frame_restart in IDLE: the raster address becomes 0 next cycle. If a request is also being launched that cycle, it uses address 0.
- frame_restart in REQUEST: the in-flight write completes at its original address. A pending flag forces the next address to 0 instead of incrementing, then clears.
- frame_restart never flushes FIFO contents.
- busy = (fifo_level!=0) | mem_write_request.

Test Plan:
- Reset with pixel_clock held high, release, no strobe toggle -> fifo_level stays 0, no mem_write_request.
- Three pixels 0xABC, 0x123, 0xFFF with ack returned 1 cycle after each request -> writes at addresses 0,1,2 with those data in order; busy falls after the last ack.
- Ack delayed 10 cycles -> address and data held constant during the wait; no pop until ack.
- Hold ack low and send FIFO_DEPTH+1 pixels -> fifo_level=16, fifo_overflow=1, the 17th pixel is absent after drain.
- Preload raster address to 76799 by streaming, then one more pixel -> written at 76799, the following pixel written at 0.
- frame_restart during REQUEST at address 5 -> write completes at 5, next write at 0; restart in IDLE at address 9 -> next write at 0.

Source files
------------

// File: rtl/pixel_write_controller.sv
// Pixel write controller: synchronises the broker's pixel strobe, buffers pixels
// in a small FIFO and drains them to framebuffer memory at raster addresses.
module pixel_write_controller #(
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int ADDR_WIDTH   = 17,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          system_clock,
  input  logic                          reset_n,
  input  logic                          pixel_clock,
  input  logic [11:0]                   pixel_data,
  input  logic                          frame_restart,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [11:0]                   mem_data,
  output logic                          mem_write_request,
  input  logic                          mem_write_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_overflow,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WIDTH*FRAME_HEIGHT-1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);
  localparam logic [PW-1:0]         ONE_P     = PW'(1);
  localparam logic [PW:0]           ONE_L     = (PW+1)'(1);
  localparam logic [PW:0]           FULL_L    = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, REQUEST} state_e;

  // Strobe synchroniser; flops reset high so a strobe already high at release is not a rise
  logic sync1_q, sync2_q, edge_q, push_q;

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
      push_q  <= 1'b0;
    end else begin
      sync1_q <= pixel_clock;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      push_q  <= sync2_q & ~edge_q;
    end
  end

  // Pixel FIFO
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   level_q;
  logic          ovf_q;
  logic          full, do_push, do_pop;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   raster_q, raster_d, addr_q;
  logic [11:0]             data_q;
  logic                    req_q, pend_q;

  assign full    = (level_q == FULL_L);
  assign do_push = push_q & ~full;
  assign do_pop  = req_q & mem_write_ack;

  always_ff @(posedge system_clock) begin
    if (do_push) mem_q[wr_ptr_q] <= pixel_data;
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ONE_P;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ONE_P;
      if (push_q && full) ovf_q <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + ONE_L;
        2'b01:   level_q <= level_q - ONE_L;
        default: level_q <= level_q;
      endcase
    end
  end

  // A restart seen during a request (pending or on the ack cycle itself) re-homes to 0
  assign raster_d = (pend_q || frame_restart || raster_q == LAST_ADDR) ? '0 : raster_q + ONE_A;

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      raster_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      req_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_restart) raster_q <= '0;
          if (level_q != '0) begin
            addr_q  <= frame_restart ? '0 : raster_q;
            data_q  <= mem_q[rd_ptr_q];
            req_q   <= 1'b1;
            state_q <= REQUEST;
          end
        end
        REQUEST: begin
          if (mem_write_ack) begin
            raster_q <= raster_d;
            pend_q   <= 1'b0;
            req_q    <= 1'b0;
            state_q  <= IDLE;
          end else if (frame_restart) begin
            pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address       = addr_q;
  assign mem_data          = data_q;
  assign mem_write_request = req_q;
  assign fifo_level        = level_q;
  assign fifo_overflow     = ovf_q;
  assign busy              = (level_q != '0) | req_q;

endmodule

// File: tb/tb_pixel_write_controller.sv
// Directed bench for pixel_write_controller; frame shrunk to 8x4 so end-of-frame
// wrap (last address 31) is reachable in a short run.
module tb_pixel_write_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pclk = 1'b1;
  logic [11:0] pdata = '0;
  logic        restart = 1'b0;
  logic        ack = 1'b0;
  logic [16:0] addr;
  logic [11:0] data;
  logic        req;
  logic [4:0]  level;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_write_controller #(
    .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .ADDR_WIDTH(17), .FIFO_DEPTH(16)
  ) dut (
    .system_clock(clk), .reset_n(rst_n), .pixel_clock(pclk), .pixel_data(pdata),
    .frame_restart(restart), .mem_address(addr), .mem_data(data),
    .mem_write_request(req), .mem_write_ack(ack), .fifo_level(level),
    .fifo_overflow(ovf), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pixel(input logic [11:0] d);
    @(negedge clk);
    pclk  = 1'b0;
    pdata = d;
    repeat (3) @(negedge clk);
    pclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_write(input logic [16:0] a, input logic [11:0] d,
                              input int dly, input bit rs);
    int n = 0;
    logic [4:0] lvl;
    while (req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", {31'd0, req}, 32'd1);
    if (req !== 1'b1) return;
    chk("addr", {15'd0, addr}, {15'd0, a});
    chk("data", {20'd0, data}, {20'd0, d});
    lvl = level;
    for (int i = 0; i < dly; i++) begin
      if (rs && i == 0) restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("hold_addr", {15'd0, addr}, {15'd0, a});
      chk("hold_data", {20'd0, data}, {20'd0, d});
      chk("hold_req", {31'd0, req}, 32'd1);
      chk("no_pop", {27'd0, level}, {27'd0, lvl});
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("req_drop", {31'd0, req}, 32'd0);
    chk("pop", {27'd0, level}, {27'd0, lvl} - 32'd1);
  endtask

  initial begin
    // Reset with strobe already high; release must not create a push
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_req",   {31'd0, req},   32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
    chk("rst_addr",  {15'd0, addr},  32'd0);
    chk("rst_data",  {20'd0, data},  32'd0);

    // Three pixels, ack one cycle after each request
    send_pixel(12'hABC);
    send_pixel(12'h123);
    send_pixel(12'hFFF);
    chk("lvl3", {27'd0, level}, 32'd3);
    chk("busy3", {31'd0, busy}, 32'd1);
    expect_write(17'd0, 12'hABC, 1, 1'b0);
    expect_write(17'd1, 12'h123, 1, 1'b0);
    expect_write(17'd2, 12'hFFF, 1, 1'b0);
    chk("busy_fall", {31'd0, busy}, 32'd0);

    // Long ack delay: everything held, nothing popped
    send_pixel(12'h5A5);
    expect_write(17'd3, 12'h5A5, 10, 1'b0);

    // Overflow: 17 pixels with ack held low
    for (int i = 0; i < 17; i++) send_pixel(12'h100 + 12'(i));
    chk("ovf_level", {27'd0, level}, 32'd16);
    chk("ovf_flag",  {31'd0, ovf},   32'd1);
    for (int i = 0; i < 16; i++) expect_write(17'd4 + 17'(i), 12'h100 + 12'(i), 0, 1'b0);
    repeat (10) @(negedge clk);
    chk("no_17th_req", {31'd0, req},   32'd0);
    chk("drained",     {27'd0, level}, 32'd0);
    chk("ovf_sticky",  {31'd0, ovf},   32'd1);

    // Stream to last frame address then wrap
    for (int i = 20; i < 31; i++) begin
      send_pixel(12'h800 + 12'(i));
      expect_write(17'(i), 12'h800 + 12'(i), 0, 1'b0);
    end
    send_pixel(12'hE1F);
    expect_write(17'd31, 12'hE1F, 0, 1'b0);
    send_pixel(12'hE20);
    expect_write(17'd0, 12'hE20, 0, 1'b0);

    // Restart during a request at address 5
    for (int i = 1; i < 5; i++) begin
      send_pixel(12'h600 + 12'(i));
      expect_write(17'(i), 12'h600 + 12'(i), 0, 1'b0);
    end
    send_pixel(12'hC05);
    expect_write(17'd5, 12'hC05, 3, 1'b1);
    send_pixel(12'hC00);
    expect_write(17'd0, 12'hC00, 0, 1'b0);

    // Restart while idle at address 9
    for (int i = 1; i < 9; i++) begin
      send_pixel(12'h700 + 12'(i));
      expect_write(17'(i), 12'h700 + 12'(i), 0, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    send_pixel(12'hD00);
    expect_write(17'd0, 12'hD00, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
